// File: rtl/wb_uart_master.sv
// -----------------------------------------------------------------------------
// wb_uart_master
//
// Wishbone B3 classic single-cycle bus master for the UART register bus.
// Each command taken on the valid/ready command port runs one Wishbone cycle.
// The result comes back as exactly one response on the valid/ready response
// port. That response is either the completion or a timeout error. The UART
// interrupt line is also registered and passed through.
//
// Ports:
//   clk, wb_rst_i          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready decoded from state)
//   cmd_we/adr/dat         command: type, register index, write data
//   rsp_valid/rsp_ready    response handshake
//   rsp_we/dat/err         response: echoed type, read data, timeout flag
//   wb_*_o / wb_*_i        Wishbone master signals toward the UART slave
//   int_i / irq_o          UART interrupt in, registered copy out
// -----------------------------------------------------------------------------
module wb_uart_master #(
    parameter int               ADDR_W    = 3,
    parameter int               DATA_W    = 8,
    parameter int               SEL_W     = 4,
    parameter logic [SEL_W-1:0] SEL_VALUE = SEL_W'(4'b0001),
    parameter int               TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_adr,
    input  logic [DATA_W-1:0] cmd_dat,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_dat,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic              wb_we_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    input  logic              wb_ack_i,
    input  logic              int_i,
    output logic              irq_o
);

    // A timeout of 0 still needs a 1-bit counter so the declarations stay legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             timeout_hit_s;

    // Only idle can take a command; this is the one unregistered output.
    assign cmd_ready = (state_r == IDLE);

    // A disabled timeout never fires; otherwise fire on the last allowed wait cycle.
    assign timeout_hit_s = (TIMEOUT != 32'sd0) && (cnt_r == CNT_LAST);

    // Command/bus/response FSM with all bus and response outputs registered.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            wb_sel_o  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        wb_we_o  <= cmd_we;
                        wb_adr_o <= cmd_adr;
                        // Reads never put stale write data on the bus.
                        wb_dat_o <= cmd_we ? cmd_dat : '0;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_sel_o <= SEL_VALUE;
                        cnt_r    <= '0;
                        state_r  <= BUS;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                BUS: begin
                    // The counter saturates so it can never wrap into a false match.
                    if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_r <= cnt_r;
                    end
                    // Ack wins over a timeout that lands on the same edge.
                    if (wb_ack_i) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_sel_o  <= '0;
                        wb_we_o   <= 1'b0;
                        wb_adr_o  <= '0;
                        wb_dat_o  <= '0;
                        rsp_valid <= 1'b1;
                        rsp_we    <= wb_we_o;
                        rsp_err   <= 1'b0;
                        rsp_dat   <= wb_we_o ? '0 : wb_dat_i;
                        state_r   <= RESP;
                    end else if (timeout_hit_s) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_sel_o  <= '0;
                        wb_we_o   <= 1'b0;
                        wb_adr_o  <= '0;
                        wb_dat_o  <= '0;
                        rsp_valid <= 1'b1;
                        rsp_we    <= wb_we_o;
                        rsp_err   <= 1'b1;
                        rsp_dat   <= '0;
                        state_r   <= RESP;
                    end else begin
                        state_r   <= BUS;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_dat   <= '0;
                        state_r   <= IDLE;
                    end else begin
                        state_r   <= RESP;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    rsp_valid <= 1'b0;
                    wb_cyc_o  <= 1'b0;
                    wb_stb_o  <= 1'b0;
                end
            endcase
        end
    end

    // Interrupt is a plain one-cycle register, independent of the FSM.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= int_i;
        end
    end

endmodule

// File: tb/tb_wb_uart_master.sv
// -----------------------------------------------------------------------------
// tb_wb_uart_master
//
// Directed bench for wb_uart_master using the default parameters
// (TIMEOUT=16, SEL_VALUE=4'b0001). Inputs change and outputs are sampled
// 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_wb_uart_master;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_we;
    logic [2:0] cmd_adr;
    logic [7:0] cmd_dat;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_we;
    logic [7:0] rsp_dat;
    logic       rsp_err;
    logic [2:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_we_o;
    logic       wb_stb_o;
    logic       wb_cyc_o;
    logic [3:0] wb_sel_o;
    logic       wb_ack_i;
    logic       int_i;
    logic       irq_o;

    int total = 0;
    int bad   = 0;

    wb_uart_master dut (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_we    (rsp_we),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_dat_i  (wb_dat_i),
        .wb_we_o   (wb_we_o),
        .wb_stb_o  (wb_stb_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_sel_o  (wb_sel_o),
        .wb_ack_i  (wb_ack_i),
        .int_i     (int_i),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for exactly one accepting edge.
    task automatic issue(input logic we, input logic [2:0] adr, input logic [7:0] dat);
        check("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Accept the pending response and confirm the block is idle again.
    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_after_hs", {31'd0, rsp_valid}, 32'd0);
        check("cmd_ready_after_hs", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        wb_rst_i  = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 3'd0;
        cmd_dat   = 8'h00;
        rsp_ready = 1'b0;
        wb_dat_i  = 8'h00;
        wb_ack_i  = 1'b0;
        int_i     = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_cyc",       {31'd0, wb_cyc_o},  32'd0);
        check("rst_stb",       {31'd0, wb_stb_o},  32'd0);
        check("rst_sel",       {28'd0, wb_sel_o},  32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_irq",       {31'd0, irq_o},     32'd0);
        wb_rst_i = 1'b0;
        tick();

        // ---------------- write, zero wait ----------------
        issue(1'b1, 3'd3, 8'h83);
        check("wr_cyc",       {31'd0, wb_cyc_o},  32'd1);
        check("wr_stb",       {31'd0, wb_stb_o},  32'd1);
        check("wr_we",        {31'd0, wb_we_o},   32'd1);
        check("wr_adr",       {29'd0, wb_adr_o},  32'd3);
        check("wr_dat",       {24'd0, wb_dat_o},  32'h83);
        check("wr_sel",       {28'd0, wb_sel_o},  32'd1);
        check("wr_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("wr_cyc_drop",  {31'd0, wb_cyc_o},  32'd0);
        check("wr_stb_drop",  {31'd0, wb_stb_o},  32'd0);
        check("wr_we_drop",   {31'd0, wb_we_o},   32'd0);
        check("wr_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("wr_rsp_we",    {31'd0, rsp_we},    32'd1);
        check("wr_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("wr_rsp_dat",   {24'd0, rsp_dat},   32'd0);
        take_rsp();

        // ---------------- read, two wait states ----------------
        issue(1'b0, 3'd5, 8'hFF);
        check("rd_dat_o_zero", {24'd0, wb_dat_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("rd_cyc_high", {31'd0, wb_cyc_o}, 32'd1);
            check("rd_stb_high", {31'd0, wb_stb_o}, 32'd1);
            check("rd_adr_hold", {29'd0, wb_adr_o}, 32'd5);
            check("rd_no_rsp",   {31'd0, rsp_valid}, 32'd0);
            if (i == 2) begin
                wb_ack_i = 1'b1;
                wb_dat_i = 8'h60;
            end
            tick();
        end
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        check("rd_cyc_drop",  {31'd0, wb_cyc_o},  32'd0);
        check("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd_rsp_we",    {31'd0, rsp_we},    32'd0);
        check("rd_rsp_dat",   {24'd0, rsp_dat},   32'h60);
        check("rd_rsp_err",   {31'd0, rsp_err},   32'd0);
        take_rsp();

        // ---------------- timeout: 16 cycles without ack ----------------
        issue(1'b1, 3'd2, 8'h11);
        for (int i = 0; i < 16; i++) begin
            check("to_cyc_high", {31'd0, wb_cyc_o},  32'd1);
            check("to_no_rsp",   {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        check("to_cyc_drop",  {31'd0, wb_cyc_o},  32'd0);
        check("to_stb_drop",  {31'd0, wb_stb_o},  32'd0);
        check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("to_rsp_err",   {31'd0, rsp_err},   32'd1);
        check("to_rsp_dat",   {24'd0, rsp_dat},   32'd0);
        check("to_rsp_we",    {31'd0, rsp_we},    32'd1);
        take_rsp();
        check("to_err_clear", {31'd0, rsp_err},   32'd0);

        // follow-up read to adr 0 completes normally
        issue(1'b0, 3'd0, 8'h00);
        check("fu_adr", {29'd0, wb_adr_o}, 32'd0);
        check("fu_cyc", {31'd0, wb_cyc_o}, 32'd1);
        wb_ack_i = 1'b1;
        wb_dat_i = 8'h3C;
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        check("fu_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("fu_rsp_err",   {31'd0, rsp_err},   32'd0);
        check("fu_rsp_dat",   {24'd0, rsp_dat},   32'h3C);
        take_rsp();

        // ---------------- response backpressure ----------------
        issue(1'b0, 3'd1, 8'h00);
        wb_ack_i = 1'b1;
        wb_dat_i = 8'hA5;
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_dat",   {24'd0, rsp_dat},   32'hA5);
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            tick();
        end
        take_rsp();

        // ---------------- reset during a bus wait ----------------
        issue(1'b0, 3'd4, 8'h00);
        tick();
        check("mr_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
        wb_rst_i = 1'b1;
        #1;
        check("mr_cyc_async",  {31'd0, wb_cyc_o},  32'd0);
        check("mr_stb_async",  {31'd0, wb_stb_o},  32'd0);
        check("mr_rsp_async",  {31'd0, rsp_valid}, 32'd0);
        tick();
        wb_rst_i = 1'b0;
        check("mr_cmd_ready",  {31'd0, cmd_ready}, 32'd1);
        // A late ack from the slave must not revive the aborted command.
        wb_ack_i = 1'b1;
        wb_dat_i = 8'h77;
        tick();
        wb_ack_i = 1'b0;
        wb_dat_i = 8'h00;
        for (int i = 0; i < 3; i++) begin
            check("mr_no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
            check("mr_idle_cyc",     {31'd0, wb_cyc_o},  32'd0);
            tick();
        end

        // ---------------- spurious ack in idle ----------------
        wb_ack_i = 1'b1;
        tick();
        wb_ack_i = 1'b0;
        check("sp_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("sp_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("sp_cyc",       {31'd0, wb_cyc_o},  32'd0);
        tick();
        check("sp_rsp_later", {31'd0, rsp_valid}, 32'd0);

        // ---------------- interrupt register ----------------
        int_i = 1'b1;
        check("irq_not_yet", {31'd0, irq_o}, 32'd0);
        tick();
        int_i = 1'b0;
        check("irq_high", {31'd0, irq_o}, 32'd1);
        tick();
        check("irq_low",  {31'd0, irq_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_uart_master.md
Name: wb_uart_master

Overview:
Wishbone B3 classic single-cycle bus master that drives the UART IP core register bus. It takes register read and write commands from a valid/ready command port and runs one Wishbone cycle per command. Each command yields exactly one response on a valid/ready response port, either the completion or a timeout error. It also registers the UART interrupt line. It sits between the test/CPU-side command source and the UART slave.

Parameters:
ADDR_W, 3, Wishbone address width (UART register index).
DATA_W, 8, Wishbone data width.
SEL_W, 4, byte-select width.
SEL_VALUE, 4'b0001, constant driven on wb_sel_o during a cycle.
TIMEOUT, 16, max cycles waiting for ack before error; 0 disables timeout.

Ports:
clk  in  1  system clock, all logic on rising edge
wb_rst_i  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept command
cmd_we  in  1  1=write, 0=read
cmd_adr  in  ADDR_W  register address
cmd_dat  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response present
rsp_ready  in  1  response consumer ready
rsp_we  out  1  echo of command type
rsp_dat  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  1=cycle timed out
wb_adr_o  out  ADDR_W  Wishbone address
wb_dat_o  out  DATA_W  Wishbone write data
wb_dat_i  in  DATA_W  Wishbone read data
wb_we_o  out  1  write enable
wb_stb_o  out  1  strobe
wb_cyc_o  out  1  cycle
wb_sel_o  out  SEL_W  byte select
wb_ack_i  in  1  slave acknowledge
int_i  in  1  UART interrupt
irq_o  out  1  int_i registered one cycle

Behaviour:
- Clock is clk. Reset is wb_rst_i, asynchronous and active-high.
- All outputs are registered except cmd_ready, which is decoded from the state.
- Reset values: every output 0 except cmd_ready, which is 1 because the state resets to IDLE. Timeout counter resets to 0.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge N: latch we, adr and dat (dat forced to 0 for reads) onto wb_we_o, wb_adr_o and wb_dat_o.
  - wb_cyc_o=wb_stb_o=1 and wb_sel_o=SEL_VALUE from after edge N. Counter cleared. Go to BUS.
- BUS:
  - cmd_ready=0. wb_adr_o, wb_dat_o, wb_we_o and wb_sel_o are held stable.
  - Counter increments each cycle.
  - If wb_ack_i=1 at edge M:
    - cyc, stb, sel, we, adr and dat go to 0 after M.
    - rsp_valid=1 and rsp_we=latched we. rsp_err=0.
    - rsp_dat=wb_dat_i sampled at M for reads, 0 for writes.
    - Go to RESP.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1 at an edge: drop bus signals as above, rsp_valid=1, rsp_err=1, rsp_dat=0. Go to RESP.
  - Ack takes priority over timeout on the same edge.
- RESP:
  - cmd_ready=0.
  - rsp_* held stable while rsp_valid&!rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid=0, rsp_err=0, rsp_dat=0. Go to IDLE.
  - The next command can be accepted one cycle later, so throughput is at most 1 transaction per 3 cycles.
- Zero-wait-state slave: cyc/stb are high exactly 1 cycle. Command to response is 2 edges.
- wb_ack_i in IDLE or RESP is ignored; no state or output change.
- cmd_valid is ignored in BUS and RESP; the command source holds it.
- Counter is wide enough for TIMEOUT (clog2(TIMEOUT+1)) and saturates; it never wraps.
- irq_o <= int_i every edge, independent of the FSM.
- Reset mid-operation (any state): cyc/stb drop immediately and asynchronously. Any pending response is discarded. FSM goes to IDLE. No response is generated for the aborted command.

Test Plan:
- Write, zero-wait: cmd we=1 adr=3 dat=8'h83; slave acks first cycle -> one cycle with cyc=stb=we=1, adr=3, dat_o=8'h83, sel=4'b0001; rsp_valid=1, rsp_we=1, rsp_err=0, rsp_dat=0.
- Read with 2 wait states: cmd we=0 adr=5; ack on 3rd cycle with wb_dat_i=8'h60 -> cyc/stb high exactly 3 cycles, adr stable at 5; rsp_dat=8'h60, rsp_err=0.
- Timeout: TIMEOUT=16, slave never acks -> cyc/stb high exactly 16 cycles then low; rsp_err=1, rsp_dat=0; a following read to adr=0 completes normally.
- Backpressure: read returns 8'hA5, rsp_ready low 5 cycles -> rsp_valid and rsp_dat=8'hA5 held; cmd_ready=0 throughout; cmd_ready=1 the cycle after the handshake.
- Reset mid-cycle: assert wb_rst_i during BUS wait -> cyc/stb/rsp_valid 0 immediately; after release cmd_ready=1 and no stale response appears.
- Spurious ack and irq: wb_ack_i pulsed in IDLE -> no response; int_i pulsed 1 cycle -> irq_o high exactly the following cycle.
